// File: rtl/kmeans_ram_arbiter.sv
// kmeans_ram_arbiter: shares the merged two-RAM point store (RAM1 holds word
// bits [49:0], RAM2 holds bits [90:50] zero-extended) between the host/regfile
// port and the read-only core streaming port.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   go_signal              1 = core preferred, 0 = host preferred
//   host_req/we/addr/wdata host access request (read or write)
//   host_gnt               host request accepted this cycle (combinational)
//   host_rvalid/rdata      host read return
//   core_req/addr          core read request
//   core_gnt               core request accepted this cycle (combinational)
//   core_rvalid/rdata      core read return
//   ram_addr, ram1/2_din   shared RAM address and write data (registered)
//   ram_web/oeb/csb        active-low RAM strobes (registered)
//   ram1_dout, ram2_dout   RAM read data
//
// Optional build macro ARB_STARVE_GUARD_EN: a wait counter forces a single
// grant to the non-preferred side after MAX_WAIT cycles of waiting.
module kmeans_ram_arbiter #(
  parameter int unsigned addrWidth    = 9,
  parameter int unsigned dataWidth    = 91,
  parameter int unsigned ram_word_len = 50,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go_signal,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [addrWidth-1:0]    host_addr,
  input  logic [dataWidth-1:0]    host_wdata,
  output logic                    host_gnt,
  output logic                    host_rvalid,
  output logic [dataWidth-1:0]    host_rdata,
  input  logic                    core_req,
  input  logic [addrWidth-1:0]    core_addr,
  output logic                    core_gnt,
  output logic                    core_rvalid,
  output logic [dataWidth-1:0]    core_rdata,
  output logic [addrWidth-1:0]    ram_addr,
  output logic [ram_word_len-1:0] ram1_din,
  output logic [ram_word_len-1:0] ram2_din,
  output logic                    ram_web,
  output logic                    ram_oeb,
  output logic                    ram_csb,
  input  logic [ram_word_len-1:0] ram1_dout,
  input  logic [ram_word_len-1:0] ram2_dout
);

  localparam int unsigned HI_W = dataWidth - ram_word_len;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOST_PH = 2'd1;
  localparam logic [1:0] CORE_PH = 2'd2;
  localparam logic [1:0] SWITCH  = 2'd3;

  typedef struct packed {
    logic vld;
    logic own_core;
  } rd_tag_t;

  logic [1:0] state_q, state_d;
  logic       pend_core_q, pend_core_d;
  logic       starve_c;

  logic [addrWidth-1:0]    ram_addr_q, ram_addr_d;
  logic [ram_word_len-1:0] ram1_din_q, ram1_din_d;
  logic [ram_word_len-1:0] ram2_din_q, ram2_din_d;
  logic                    ram_web_q, ram_web_d;
  logic                    ram_oeb_q, ram_oeb_d;
  logic                    ram_csb_q, ram_csb_d;

  rd_tag_t [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic host_rvalid_q, host_rvalid_d;
  logic core_rvalid_q, core_rvalid_d;

  logic any_gnt_c, wr_c;
  logic [HI_W-1:0] rdata_hi_c;
  logic [ram_word_len-HI_W-1:0] unused_ram2_hi;

  // Grants only in the owning phase
  assign host_gnt  = host_req && (state_q == HOST_PH);
  assign core_gnt  = core_req && (state_q == CORE_PH);
  assign any_gnt_c = host_gnt || core_gnt;
  assign wr_c      = host_gnt && host_we;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic np_req_c, np_gnt_c;

  // Wait counter for whichever side is currently not preferred
  always_comb begin
    np_req_c = go_signal ? host_req : core_req;
    np_gnt_c = go_signal ? host_gnt : core_gnt;
    wait_d   = wait_q;
    if (!np_req_c || np_gnt_c) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign starve_c = np_req_c && (wait_q == WAIT_W'(MAX_WAIT));
`else
  assign starve_c = 1'b0;
`endif

  // Phase FSM next state
  always_comb begin
    state_d     = state_q;
    pend_core_d = pend_core_q;
    case (state_q)
      IDLE: begin
        if (host_req && core_req) begin
          state_d = go_signal ? CORE_PH : HOST_PH;
        end else if (host_req) begin
          state_d = HOST_PH;
        end else if (core_req) begin
          state_d = CORE_PH;
        end
      end
      HOST_PH: begin
        if (!host_req && !core_req) begin
          state_d = IDLE;
        end else if (core_req && (!host_req || go_signal || (starve_c && !go_signal))) begin
          state_d     = SWITCH;
          pend_core_d = 1'b1;
        end
      end
      CORE_PH: begin
        if (!host_req && !core_req) begin
          state_d = IDLE;
        end else if (host_req && (!core_req || !go_signal || (starve_c && go_signal))) begin
          state_d     = SWITCH;
          pend_core_d = 1'b0;
        end
      end
      SWITCH: begin
        state_d = pend_core_q ? CORE_PH : HOST_PH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_core_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_core_q <= pend_core_d;
    end
  end

  // RAM strobes for the cycle after a grant; address holds when idle
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram1_din_d = '0;
    ram2_din_d = '0;
    ram_csb_d  = 1'b1;
    ram_web_d  = 1'b1;
    ram_oeb_d  = 1'b1;
    if (any_gnt_c) begin
      ram_addr_d = host_gnt ? host_addr : core_addr;
      ram_csb_d  = 1'b0;
      if (wr_c) begin
        ram_web_d  = 1'b0;
        ram1_din_d = host_wdata[ram_word_len-1:0];
        ram2_din_d = ram_word_len'(host_wdata[dataWidth-1:ram_word_len]);
      end else begin
        ram_oeb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_q <= '0;
      ram1_din_q <= '0;
      ram2_din_q <= '0;
      ram_csb_q  <= 1'b1;
      ram_web_q  <= 1'b1;
      ram_oeb_q  <= 1'b1;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram1_din_q <= ram1_din_d;
      ram2_din_q <= ram2_din_d;
      ram_csb_q  <= ram_csb_d;
      ram_web_q  <= ram_web_d;
      ram_oeb_q  <= ram_oeb_d;
    end
  end

  // Read tag pipe: stage 0 matches the strobe cycle, the rvalid flop lands
  // on the cycle the RAM output is valid
  always_comb begin
    pipe_d[0].vld      = any_gnt_c && !wr_c;
    pipe_d[0].own_core = core_gnt;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    host_rvalid_d = pipe_q[RD_LATENCY-1].vld && !pipe_q[RD_LATENCY-1].own_core;
    core_rvalid_d = pipe_q[RD_LATENCY-1].vld &&  pipe_q[RD_LATENCY-1].own_core;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q        <= '0;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      pipe_q        <= pipe_d;
      host_rvalid_q <= host_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
    end
  end

  // RAM2 upper bits carry only zero padding
  assign rdata_hi_c     = ram2_dout[HI_W-1:0];
  assign unused_ram2_hi = ram2_dout[ram_word_len-1:HI_W];

  assign ram_addr    = ram_addr_q;
  assign ram1_din    = ram1_din_q;
  assign ram2_din    = ram2_din_q;
  assign ram_csb     = ram_csb_q;
  assign ram_web     = ram_web_q;
  assign ram_oeb     = ram_oeb_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rvalid = core_rvalid_q;
  assign host_rdata  = {rdata_hi_c, ram1_dout};
  assign core_rdata  = {rdata_hi_c, ram1_dout};

endmodule
